// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: scrolls a 6-digit window across MSG_LEN segment glyphs
// on the six HEX digits, with status on the ten LEDs.
// KEY[0] starts / holds / resumes the scroll, KEY[1] clears back to idle.
// Optional build macro: HEX_SCROLL_BLINK_EN blinks the window during the
// wrap-around pause. Left undefined, the window stays static in the pause.
module hex_scroll_ctrl #(
    parameter int MSG_LEN     = 16,
    parameter int TICK_DIV    = 12_500_000,
    parameter int DB_CYCLES   = 500_000,
    parameter int PAUSE_STEPS = 4
) (
    input  logic                   MAX10_CLK1_50,
    input  logic                   RST_N,
    input  logic [1:0]             KEY,
    input  logic [8*MSG_LEN-1:0]   MSG,
    output logic [9:0]             LED,
    output logic [47:0]            HEX
);

    localparam int POS_W   = $clog2(MSG_LEN);
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int PAUSE_W = $clog2(PAUSE_STEPS + 1);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(MSG_LEN - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_HOLD
    } ScrollState;

    logic [1:0]         r_rstSync;
    logic               w_rstN;
    logic [1:0]         r_keyMeta;
    logic [1:0]         r_keySync;
    logic [1:0]         r_dbLevel;
    logic [DB_W-1:0]    r_dbCnt [2];
    logic [1:0]         r_press;
    ScrollState         r_state;
    logic [POS_W-1:0]   r_pos;
    logic [TICK_W-1:0]  r_tickCnt;
    logic [PAUSE_W-1:0] r_pauseCnt;
`ifdef HEX_SCROLL_BLINK_EN
    logic               r_blinkOff;
`endif
    logic               w_tick;
    logic               w_blank;
    logic [7:0]         w_glyph [MSG_LEN];
    logic [47:0]        w_hexNext;
    logic [9:0]         w_ledNext;
    logic [4:0]         w_ledPos;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    // Two-flop synchronizer for the raw buttons; released level is 1.
    always_ff @(posedge MAX10_CLK1_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_keyMeta <= 2'b11;
            r_keySync <= 2'b11;
        end else begin
            r_keyMeta <= KEY;
            r_keySync <= r_keyMeta;
        end
    end

    // Debounce: accept a new level after DB_CYCLES straight mismatches and pulse on a press.
    always_ff @(posedge MAX10_CLK1_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_dbLevel <= 2'b11;
            r_press   <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_dbCnt[k] <= '0;
            end
        end else begin
            r_press <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (r_keySync[k] != r_dbLevel[k]) begin
                    if (r_dbCnt[k] == DB_LAST) begin
                        r_dbLevel[k] <= r_keySync[k];
                        r_dbCnt[k]   <= '0;
                        r_press[k]   <= ~r_keySync[k];
                    end else begin
                        r_dbCnt[k] <= r_dbCnt[k] + DB_W'(1);
                    end
                end else begin
                    r_dbCnt[k] <= '0;
                end
            end
        end
    end

    assign w_tick = ((r_state == ST_RUN) || (r_state == ST_PAUSE)) && (r_tickCnt == TICK_LAST);

    // Scroll sequencer: state, position, tick divider and pause count; KEY1 outranks KEY0.
    always_ff @(posedge MAX10_CLK1_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_tickCnt  <= '0;
            r_pauseCnt <= '0;
`ifdef HEX_SCROLL_BLINK_EN
            r_blinkOff <= 1'b0;
`endif
        end else if (r_press[1]) begin
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_tickCnt  <= '0;
            r_pauseCnt <= '0;
`ifdef HEX_SCROLL_BLINK_EN
            r_blinkOff <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pos      <= '0;
                    r_tickCnt  <= '0;
                    r_pauseCnt <= '0;
                    if (r_press[0]) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_press[0]) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_tickCnt <= w_tick ? '0 : r_tickCnt + TICK_W'(1);
                        if (w_tick) begin
                            if (r_pos == POS_LAST) begin
                                r_pos      <= '0;
                                r_pauseCnt <= '0;
                                r_state    <= ST_PAUSE;
                            end else begin
                                r_pos <= r_pos + POS_W'(1);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (r_press[0]) begin
                        r_state <= ST_HOLD;
`ifdef HEX_SCROLL_BLINK_EN
                        r_blinkOff <= 1'b0;
`endif
                    end else begin
                        r_tickCnt <= w_tick ? '0 : r_tickCnt + TICK_W'(1);
                        if (w_tick) begin
                            if (r_pauseCnt == PAUSE_LAST) begin
                                r_pauseCnt <= '0;
                                r_state    <= ST_RUN;
`ifdef HEX_SCROLL_BLINK_EN
                                r_blinkOff <= 1'b0;
`endif
                            end else begin
                                r_pauseCnt <= r_pauseCnt + PAUSE_W'(1);
`ifdef HEX_SCROLL_BLINK_EN
                                r_blinkOff <= ~r_blinkOff;
`endif
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_press[0]) begin
                        r_state    <= ST_RUN;
                        r_tickCnt  <= '0;
                        r_pauseCnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Unpack the message bus into one glyph per entry.
    for (genvar i = 0; i < MSG_LEN; i++) begin : g_glyph
        assign w_glyph[i] = MSG[8*i +: 8];
    end

    // LED[4:0] carries pos, truncated or zero-extended to five bits.
    if (POS_W >= 5) begin : g_posTrunc
        assign w_ledPos = r_pos[4:0];
    end else begin : g_posExt
        assign w_ledPos = {{(5 - POS_W){1'b0}}, r_pos};
    end

    // Glyph shown on digit d: (p + 5 - d) wrapped into 0..MSG_LEN-1.
    function automatic logic [POS_W-1:0] glyphIdx(input logic [POS_W-1:0] p, input int d);
        int idx;
        idx = int'(p) + 5 - d;
        if (idx >= MSG_LEN) begin
            idx = idx - MSG_LEN;
        end
        return POS_W'(idx);
    endfunction

    // Next display: blank in idle (and on blink-off pause ticks), otherwise the window at pos.
    always_comb begin
`ifdef HEX_SCROLL_BLINK_EN
        w_blank = (r_state == ST_IDLE) || ((r_state == ST_PAUSE) && r_blinkOff);
`else
        w_blank = (r_state == ST_IDLE);
`endif
        w_hexNext = '1;
        if (!w_blank) begin
            for (int d = 0; d < 6; d++) begin
                w_hexNext[8*d +: 8] = w_glyph[glyphIdx(r_pos, d)];
            end
        end
        w_ledNext = {(r_state == ST_RUN), (r_state == ST_PAUSE), (r_state == ST_HOLD),
                     2'b00, w_ledPos};
    end

    // Output register: HEX and LED follow state/pos one cycle later.
    always_ff @(posedge MAX10_CLK1_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            HEX <= '1;
            LED <= '0;
        end else begin
            HEX <= w_hexNext;
            LED <= w_ledNext;
        end
    end

endmodule
